// File: rtl/l2_bus_arbiter_if.sv
// generic_bus_if: request/response bus shared by the L1 miss buses and the L2 processor port.
interface generic_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic ren;
  logic wen;
  logic busy;
  modport generic_bus (input addr, wdata, byte_en, ren, wen, output rdata, busy);
  modport cpu (output addr, wdata, byte_en, ren, wen, input rdata, busy);
endinterface

// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: shares the L2 processor port between I- and D-cache miss buses
// with round-robin grants locked per transaction, and sequences L2 flushes between them.
module l2_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic RESET_LAST_GRANT = 1'b1
) (
  input logic CLK,
  input logic nRST,
  generic_bus_if.generic_bus icache_bus,
  generic_bus_if.generic_bus dcache_bus,
  generic_bus_if.cpu l2_bus,
  input logic flush_req,
  output logic flush_done,
  output logic l2_flush,
  input logic l2_flush_done
);
  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, FLUSH, FLUSH_ACK} state_t;
  state_t state, next_state;
  logic last_grant, ack_hold, req_i, req_d;
  assign req_i = icache_bus.ren | icache_bus.wen;
  assign req_d = dcache_bus.ren | dcache_bus.wen;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      last_grant <= RESET_LAST_GRANT;
      ack_hold <= 1'b0;
    end else begin
      state <= next_state;
      ack_hold <= state == FLUSH_ACK;
      if ((state == GRANT_I || state == GRANT_D) && !l2_bus.busy) last_grant <= state == GRANT_D;
    end
  end
  // ack_hold masks a still-high flush_req for the IDLE cycle right after FLUSH_ACK
  always_comb begin
    next_state = state;
    l2_bus.addr = {ADDR_WIDTH{1'b0}};
    l2_bus.wdata = {DATA_WIDTH{1'b0}};
    l2_bus.byte_en = '0;
    l2_bus.ren = 1'b0;
    l2_bus.wen = 1'b0;
    icache_bus.busy = 1'b1;
    icache_bus.rdata = {DATA_WIDTH{1'b0}};
    dcache_bus.busy = 1'b1;
    dcache_bus.rdata = {DATA_WIDTH{1'b0}};
    l2_flush = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req && !ack_hold) next_state = FLUSH;
        else if (req_i && (!req_d || last_grant)) next_state = GRANT_I;
        else if (req_d) next_state = GRANT_D;
      end
      GRANT_I: begin
        l2_bus.addr = icache_bus.addr;
        l2_bus.wdata = icache_bus.wdata;
        l2_bus.byte_en = icache_bus.byte_en;
        l2_bus.ren = icache_bus.ren;
        l2_bus.wen = icache_bus.wen;
        icache_bus.rdata = l2_bus.rdata;
        icache_bus.busy = l2_bus.busy;
        next_state = l2_bus.busy ? GRANT_I : IDLE;
      end
      GRANT_D: begin
        l2_bus.addr = dcache_bus.addr;
        l2_bus.wdata = dcache_bus.wdata;
        l2_bus.byte_en = dcache_bus.byte_en;
        l2_bus.ren = dcache_bus.ren;
        l2_bus.wen = dcache_bus.wen;
        dcache_bus.rdata = l2_bus.rdata;
        dcache_bus.busy = l2_bus.busy;
        next_state = l2_bus.busy ? GRANT_D : IDLE;
      end
      FLUSH: begin
        l2_flush = 1'b1;
        next_state = l2_flush_done ? FLUSH_ACK : FLUSH;
      end
      FLUSH_ACK: begin
        flush_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule
